// File: rtl/hazard_unit_pkg.sv
// Shared control definitions for the pipeline hazard unit: FSM state
// encoding and the NOP word that the flush datapath loads into cleared registers.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StWait = 2'd1,
        StErr  = 2'd2
    } state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    function automatic logic is_nop(input logic [31:0] instr);
        return instr == NopInstr;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-unit signal bundle: ID/EX operand info and memory status in,
// stall/flush controls and performance counters out.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_branch_taken;
    logic             mem_busy;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_branch_taken, mem_busy,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               pipe_hold, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_branch_taken, mem_busy,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               pipe_hold, mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module hazard_unit_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (inc && (value != {WIDTH{1'b1}})) begin
            value <= value + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller: load-use bubbles, taken-branch flushes and memory-wait
// freeze with a timeout watchdog, plus saturating stall/flush counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    hazard_unit_if.slave hz
);

    localparam int unsigned    WaitW    = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] MaxWaitV = WaitW'(MAX_WAIT);
    localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);

    state_e           state;
    logic [WaitW-1:0] wait_cnt;
    logic [WaitW-1:0] wait_inc;
    logic             lu;

    logic pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush;
    logic pipe_hold, mem_timeout;

    assign wait_inc = wait_cnt + WaitOne;

    assign lu = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                 (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StRun;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                StRun: begin
                    if (hz.mem_busy) begin
                        wait_cnt <= WaitOne;
                        state    <= (MAX_WAIT <= 1) ? StErr : StWait;
                    end
                end
                StWait: begin
                    if (hz.mem_busy) begin
                        wait_cnt <= wait_inc;
                        if (wait_inc >= MaxWaitV) state <= StErr;
                    end else begin
                        wait_cnt <= '0;
                        state    <= StRun;
                    end
                end
                StErr:   state <= StErr;
                default: state <= StRun;
            endcase
        end
    end

    // WAIT with mem_busy low behaves exactly like RUN, so both share one decode.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_hold    = 1'b0;
        mem_timeout  = 1'b0;
        if (!reset) begin
            unique case (state)
                StRun, StWait: begin
                    if (hz.mem_busy) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        pipe_hold   = 1'b1;
                    end else if (hz.ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                StErr: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_hold   = 1'b1;
                    mem_timeout = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.pipe_hold    = pipe_hold;
    assign hz.mem_timeout  = mem_timeout;

    hazard_unit_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (~pc_write),
        .value (hz.stall_cnt)
    );

    hazard_unit_sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (if_id_flush),
        .value (hz.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Randomised scoreboard bench for hazard_unit: a cycle-level reference model
// pushes expected outputs, a negedge monitor pops and compares.
module tb_hazard_unit;

    localparam int unsigned MaxWait = 4;
    localparam int unsigned CntW    = 4;
    localparam int          CntMax  = (1 << CntW) - 1;

    typedef struct packed {
        logic            pc_write;
        logic            if_id_write;
        logic            id_ex_bubble;
        logic            if_id_flush;
        logic            id_ex_flush;
        logic            pipe_hold;
        logic            mem_timeout;
        logic [CntW-1:0] stall_cnt;
        logic [CntW-1:0] flush_cnt;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CntW)) hz ();

    hazard_unit #(
        .MAX_WAIT (MaxWait),
        .CNT_W    (CntW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state
    int busy_run  = 0;
    bit timed_out = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;

    task automatic apply(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic busy, input logic rst);
        exp_t e;
        bit   hazard;
        @(posedge clk);
        #1;
        reset              = rst;
        hz.id_rs1          = rs1;
        hz.id_rs2          = rs2;
        hz.id_use_rs1      = u1;
        hz.id_use_rs2      = u2;
        hz.ex_rd           = rd;
        hz.ex_memread      = mr;
        hz.ex_branch_taken = br;
        hz.mem_busy        = busy;

        hazard = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e.o    = '0;
        e.o.pc_write    = 1'b1;
        e.o.if_id_write = 1'b1;
        e.o.stall_cnt   = CntW'(m_stall);
        e.o.flush_cnt   = CntW'(m_flush);
        e.tag = tag;
        e.cyc = cyc;

        if (rst) begin
            busy_run  = 0;
            timed_out = 1'b0;
        end else if (timed_out) begin
            e.o.pc_write    = 1'b0;
            e.o.if_id_write = 1'b0;
            e.o.pipe_hold   = 1'b1;
            e.o.mem_timeout = 1'b1;
        end else if (busy) begin
            e.o.pc_write    = 1'b0;
            e.o.if_id_write = 1'b0;
            e.o.pipe_hold   = 1'b1;
            busy_run++;
            if (busy_run >= MaxWait) timed_out = 1'b1;
        end else begin
            busy_run = 0;
            if (br) begin
                e.o.if_id_flush = 1'b1;
                e.o.id_ex_flush = 1'b1;
            end else if (hazard) begin
                e.o.pc_write     = 1'b0;
                e.o.if_id_write  = 1'b0;
                e.o.id_ex_bubble = 1'b1;
            end
        end
        q.push_back(e);

        if (rst) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!e.o.pc_write && m_stall < CntMax) m_stall++;
            if (e.o.if_id_flush && m_flush < CntMax) m_flush++;
        end
        cyc++;
    endtask

    task automatic idle(input string tag, input logic rst);
        apply(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, rst);
    endtask

    always @(negedge clk) begin
        obs_t got;
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            got.pc_write     = hz.pc_write;
            got.if_id_write  = hz.if_id_write;
            got.id_ex_bubble = hz.id_ex_bubble;
            got.if_id_flush  = hz.if_id_flush;
            got.id_ex_flush  = hz.id_ex_flush;
            got.pipe_hold    = hz.pipe_hold;
            got.mem_timeout  = hz.mem_timeout;
            got.stall_cnt    = hz.stall_cnt;
            got.flush_cnt    = hz.flush_cnt;
            checks++;
            if (got !== e.o) begin
                errors++;
                $display("FAIL %s cyc=%0d got pc=%b ifid=%b bub=%b fl=%b%b hold=%b to=%b st=%0d fc=%0d want pc=%b ifid=%b bub=%b fl=%b%b hold=%b to=%b st=%0d fc=%0d",
                         e.tag, e.cyc, got.pc_write, got.if_id_write, got.id_ex_bubble,
                         got.if_id_flush, got.id_ex_flush, got.pipe_hold, got.mem_timeout,
                         got.stall_cnt, got.flush_cnt, e.o.pc_write, e.o.if_id_write,
                         e.o.id_ex_bubble, e.o.if_id_flush, e.o.id_ex_flush, e.o.pipe_hold,
                         e.o.mem_timeout, e.o.stall_cnt, e.o.flush_cnt);
            end
        end
    end

    initial begin
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
        hz.ex_rd = '0; hz.ex_memread = 1'b0; hz.ex_branch_taken = 1'b0; hz.mem_busy = 1'b0;

        idle("reset", 1'b1);
        idle("post_reset", 1'b0);

        // Load-use on rs1, then release
        apply("lu_rs1", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("lu_after", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("lu_rs2", 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        // x0 and unused-source filtering
        apply("x0_filter", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("unused_rs2", 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

        // Branch beats load-use
        idle("reset2", 1'b1);
        apply("br_over_lu", 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        idle("br_after", 1'b0);

        // Memory wait with pending branch
        idle("reset3", 1'b1);
        repeat (3) apply("busy_br", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply("release_br", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("release_after", 1'b0);

        // Timeout, stickiness, and reset recovery
        idle("reset4", 1'b1);
        repeat (6) apply("busy_to", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) idle("err_sticky", 1'b0);
        idle("err_reset", 1'b1);
        idle("err_cleared", 1'b0);

        // Stall counter saturation
        idle("reset5", 1'b1);
        repeat (20) apply("sat_lu", 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("sat_after", 1'b0);

        // Random traffic with small register range to force collisions
        idle("reset6", 1'b1);
        for (int i = 0; i < 400; i++) begin
            apply("random",
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 30),
                  1'($urandom_range(0, 99) < 2));
        end

        @(posedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Stall/flush controller for the 5-stage pipeline; the counterpart of the forwarding unit.
- Forwarding resolves MEM/WB producers. This block handles what forwarding cannot:
  - load-use hazards on an EX-stage load (one-cycle bubble);
  - taken-branch redirect (flush IF/ID and ID/EX);
  - data-memory wait (full pipeline freeze, with a timeout watchdog).
- Holds saturating stall and flush performance counters.

Parameters:
- MAX_WAIT, 16, maximum consecutive mem_busy cycles tolerated before a timeout error.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- id_rs1  input  5  rs1 of instruction in ID
- id_rs2  input  5  rs2 of instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_rd  input  5  rd of instruction in EX
- ex_memread  input  1  EX instruction is a load
- ex_branch_taken  input  1  branch/jump resolved taken in EX
- mem_busy  input  1  data memory not ready this cycle
- pc_write  output  1  PC may update
- if_id_write  output  1  IF/ID register may update
- id_ex_bubble  output  1  load ID/EX with NOP controls
- if_id_flush  output  1  clear IF/ID to NOP
- id_ex_flush  output  1  clear ID/EX to NOP
- pipe_hold  output  1  freeze EX/MEM and MEM/WB
- mem_timeout  output  1  sticky timeout error
- stall_cnt  output  CNT_W  cycles with pc_write=0
- flush_cnt  output  CNT_W  taken-branch flush events

Behaviour:
- FSM states: RUN, WAIT, ERR; registered state.
- Control outputs are combinational from state + inputs, effective in the same cycle.
- Reset, synchronous:
  - state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
  - While reset is high, outputs take RUN no-hazard values: pc_write=1, if_id_write=1, all others 0.
- Load-use hazard: lu = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN priority (highest first):
  1. mem_busy:
     - pc_write=0, if_id_write=0, pipe_hold=1, id_ex_bubble=0, no flush.
     - Next state WAIT; wait counter=1.
  2. ex_branch_taken:
     - if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1.
     - lu is ignored because the ID instruction is wrong-path.
     - flush_cnt++.
  3. lu:
     - pc_write=0, if_id_write=0, id_ex_bubble=1.
     - Lasts exactly one cycle; the load then moves to MEM and forwarding takes over.
  4. Otherwise: pc_write=1, if_id_write=1, all others 0.
- WAIT:
  - While mem_busy: same freeze outputs as RUN/mem_busy; wait counter++.
  - If the counter reaches MAX_WAIT while mem_busy is still high, next state is ERR.
  - On mem_busy=0: return to RUN and evaluate RUN priorities in that same cycle. A branch or lu held stable during the freeze is acted on then, with no lost or duplicated event.
- ERR:
  - mem_timeout=1.
  - pc_write=0, if_id_write=0, pipe_hold=1.
  - Exit only by reset.
- stall_cnt: increments every cycle pc_write=0 (includes lu, WAIT and ERR cycles).
- Both counters saturate at all-ones, with no wrap.
- ex_rd=0 never triggers lu, even when ex_memread=1.
- Simultaneous mem_busy and ex_branch_taken: freeze only. The flush and flush_cnt++ occur once, in the release cycle.
- Reset in WAIT or ERR: immediate return to RUN; counters clear.

Decomposition:
- Shared control package:
  - FSM state encoding (RUN=2'd0, WAIT=2'd1, ERR=2'd2);
  - NOP instruction constant 32'h00000013, used by the flush datapath.
- One sub-module, sat_counter (width param, inc, clear, value), instantiated twice.
- The wait counter is internal: $clog2(MAX_WAIT+1) bits.

Test Plan:
- Load-use on rs1: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; next cycle (ex_memread=0) back to normal; stall_cnt=1.
- x0 and unused-source filtering:
  - ex_rd=0, id_rs1=0 -> no stall.
  - ex_rd=7, id_rs2=7, id_use_rs2=0 -> no stall.
- Branch beats load-use: ex_branch_taken=1 together with a lu condition -> if_id_flush=1, id_ex_flush=1, id_ex_bubble=0, pc_write=1; flush_cnt=1, stall_cnt=0.
- Memory wait with pending branch: mem_busy=1 for 3 cycles while ex_branch_taken=1 -> pipe_hold=1 and no flush for 3 cycles; in the release cycle both flushes pulse once; stall_cnt=3, flush_cnt=1.
- Timeout: MAX_WAIT=4, mem_busy held high -> mem_timeout rises after 4 busy cycles and stays high after mem_busy drops; a reset pulse clears it, state returns to RUN, counters read 0.
- Saturation: CNT_W=4, 20 consecutive lu stall cycles -> stall_cnt holds at 15.
